wizard_top: RTL and testbench



---
 rtl/wizard_top.sv | 117 +++++++++++
 tb/tb_wizard_top.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wizard_top.sv
// VGA timing generator with a colour-bar test pattern, a border and a moving white square.
// One pixel per clk; vgaData is registered, so it trails the counters by one cycle.
module wizard_top #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic [13:0] vgaData
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
    localparam int VW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;

    localparam logic [HW-1:0] H_MAX    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_LAST   = HW'(H_VISIBLE - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] BAR_W    = HW'(H_VISIBLE / 8);

    localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [7:0]    frame_cnt;
    logic          h_wrap;
    logic          v_wrap;

    logic          hsync_p0;
    logic          vsync_p0;
    logic          vld_p0;
    logic [11:0]   rgb_p0;
    logic [9:0]    sq_lo;
    logic [9:0]    sq_hi;
    logic          in_sq;
    logic          border;
    logic [2:0]    bar_idx;

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 12'hFFF;
            3'd1:    bar_colour = 12'hFF0;
            3'd2:    bar_colour = 12'h0FF;
            3'd3:    bar_colour = 12'h0F0;
            3'd4:    bar_colour = 12'hF0F;
            3'd5:    bar_colour = 12'hF00;
            3'd6:    bar_colour = 12'h00F;
            default: bar_colour = 12'h000;
        endcase
    endfunction

    assign h_wrap = (h_cnt == H_MAX);
    assign v_wrap = (v_cnt == V_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
                if (v_wrap) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    // ---- stage p0: pixel decode from the current counters ----
    always_comb begin
        hsync_p0 = ~((h_cnt >= HS_START) && (h_cnt < HS_END));
        vsync_p0 = ~((v_cnt >= VS_START) && (v_cnt < VS_END));
        vld_p0   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        // Square bounds stay in 10 bits so frame_cnt+31 never wraps back to the top-left.
        sq_lo    = {2'b00, frame_cnt};
        sq_hi    = sq_lo + 10'd31;
        in_sq    = (h_cnt >= HW'(sq_lo)) && (h_cnt <= HW'(sq_hi)) &&
                   (v_cnt >= VW'(sq_lo)) && (v_cnt <= VW'(sq_hi));
        border   = (h_cnt == '0) || (h_cnt == H_LAST) || (v_cnt == '0) || (v_cnt == V_LAST);
        bar_idx  = 3'(h_cnt / BAR_W);
        rgb_p0   = 12'h000;
        if (vld_p0) begin
            if (in_sq) begin
                rgb_p0 = 12'hFFF;
            end else if (border) begin
                rgb_p0 = 12'h888;
            end else begin
                rgb_p0 = bar_colour(bar_idx);
            end
        end
    end

    // ---- stage p1: registered output bus ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vgaData <= 14'h3000;
        end else begin
            vgaData <= {hsync_p0, vsync_p0, rgb_p0};
        end
    end

endmodule

// File: tb/tb_wizard_top.sv
// Bench for wizard_top on a reduced raster (80x48 total, 64x40 visible) so many frames fit in a short run.
// Expected pixels come from a raster-position model indexed by output cycles since reset release.
module tb_wizard_top;

    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 40, VF = 2, VS = 3, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk;
    logic        reset;
    logic [13:0] vgaData;

    int compared;
    int mismatched;
    int k;

    typedef struct {
        int          h;
        int          v;
        logic [13:0] exp;
    } spot_t;

    wizard_top #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .vgaData(vgaData)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic logic [11:0] bar_rgb(input int b);
        logic [11:0] c;
        case (b)
            0: c = 12'hFFF;
            1: c = 12'hFF0;
            2: c = 12'h0FF;
            3: c = 12'h0F0;
            4: c = 12'hF0F;
            5: c = 12'hF00;
            6: c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    // Expected bus for the idx-th pixel emitted after reset release.
    function automatic logic [13:0] model(input int idx);
        int h, v, f;
        logic hs, vs;
        logic [11:0] rgb;
        h   = idx % HT;
        v   = (idx / HT) % VT;
        f   = (idx / FT) % 256;
        hs  = !((h >= HV + HF) && (h < HV + HF + HS));
        vs  = !((v >= VV + VF) && (v < VV + VF + VS));
        rgb = 12'h000;
        if (h < HV && v < VV) begin
            if (h >= f && h <= f + 31 && v >= f && v <= f + 31) rgb = 12'hFFF;
            else if (h == 0 || h == HV - 1 || v == 0 || v == VV - 1) rgb = 12'h888;
            else rgb = bar_rgb(h / (HV / 8));
        end
        return {hs, vs, rgb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input int target);
        while (k < target) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (vgaData !== 14'h3000) begin
                mismatched++;
                $display("FAIL reset_hold cycle %0d: got %h want 3000", i, vgaData);
            end
        end
        reset = 1'b0;
        tick();
        k = 0;
        compared++;
        if (vgaData !== 14'h3FFF) begin
            mismatched++;
            $display("FAIL reset_release: got %h want 3fff", vgaData);
        end
    endtask

    task automatic test_line();
        int   falls[$];
        int   lows;
        int   f0, f1;
        logic prev;
        lows = 0;
        prev = vgaData[13];
        for (int j = 0; j < 2 * HT; j++) begin
            tick();
            k++;
            if (prev && !vgaData[13]) falls.push_back(k);
            if (!vgaData[13] && falls.size() == 1) lows++;
            prev = vgaData[13];
        end
        f0 = (falls.size() > 0) ? falls[0] : -1;
        f1 = (falls.size() > 1) ? falls[1] : -1;
        compared++;
        if (falls.size() != 2) begin
            mismatched++;
            $display("FAIL hsync_pulses: got %0d want 2", falls.size());
        end
        compared++;
        if (f0 != HV + HF) begin
            mismatched++;
            $display("FAIL hsync_start: got %0d want %0d", f0, HV + HF);
        end
        compared++;
        if (lows != HS) begin
            mismatched++;
            $display("FAIL hsync_width: got %0d want %0d", lows, HS);
        end
        compared++;
        if (f1 - f0 != HT) begin
            mismatched++;
            $display("FAIL hsync_period: got %0d want %0d", f1 - f0, HT);
        end
    endtask

    task automatic test_pixels(input int frame, input spot_t spots[]);
        foreach (spots[i]) begin
            advance_to(frame * FT + spots[i].v * HT + spots[i].h);
            compared++;
            if (vgaData !== spots[i].exp) begin
                mismatched++;
                $display("FAIL pixel f%0d h%0d v%0d: got %h want %h",
                         frame, spots[i].h, spots[i].v, vgaData, spots[i].exp);
            end
        end
    endtask

    task automatic test_frame(input int k_end);
        int   falls[$];
        int   lows;
        int   f0, f1;
        logic prev;
        lows = 0;
        prev = vgaData[12];
        while (k < k_end) begin
            tick();
            k++;
            compared++;
            if (vgaData !== model(k)) begin
                mismatched++;
                $display("FAIL stream k=%0d: got %h want %h", k, vgaData, model(k));
            end
            if (prev && !vgaData[12]) falls.push_back(k);
            if (!vgaData[12] && falls.size() == 1) lows++;
            prev = vgaData[12];
        end
        f0 = (falls.size() > 0) ? falls[0] : -1;
        f1 = (falls.size() > 1) ? falls[1] : -1;
        compared++;
        if (falls.size() != 10) begin
            mismatched++;
            $display("FAIL vsync_pulses: got %0d want 10", falls.size());
        end
        compared++;
        if (f0 != (VV + VF) * HT) begin
            mismatched++;
            $display("FAIL vsync_start: got %0d want %0d", f0, (VV + VF) * HT);
        end
        compared++;
        if (lows != VS * HT) begin
            mismatched++;
            $display("FAIL vsync_width: got %0d want %0d", lows, VS * HT);
        end
        compared++;
        if (f1 - f0 != FT) begin
            mismatched++;
            $display("FAIL frame_period: got %0d want %0d", f1 - f0, FT);
        end
    endtask

    task automatic test_mid_reset();
        advance_to(10 * FT + (VV + VF) * HT + HV + HF + 1);
        compared++;
        if (vgaData !== 14'h0000) begin
            mismatched++;
            $display("FAIL mid_reset_pre: got %h want 0000", vgaData);
        end
        reset = 1'b1;
        tick();
        compared++;
        if (vgaData !== 14'h3000) begin
            mismatched++;
            $display("FAIL mid_reset_abort: got %h want 3000", vgaData);
        end
        reset = 1'b0;
        tick();
        k = 0;
        compared++;
        if (vgaData !== 14'h3FFF) begin
            mismatched++;
            $display("FAIL mid_reset_restart: got %h want 3fff", vgaData);
        end
        for (int j = 0; j < FT; j++) begin
            tick();
            k++;
            compared++;
            if (vgaData !== model(k)) begin
                mismatched++;
                $display("FAIL after_reset k=%0d: got %h want %h", k, vgaData, model(k));
            end
        end
    endtask

    task automatic test_random_reset();
        int n, len;
        for (int it = 0; it < 3; it++) begin
            n   = $urandom_range(2500, 50);
            len = $urandom_range(4, 1);
            for (int j = 0; j < n; j++) begin
                tick();
                k++;
                compared++;
                if (vgaData !== model(k)) begin
                    mismatched++;
                    $display("FAIL rand_stream it%0d k=%0d: got %h want %h", it, k, vgaData, model(k));
                end
            end
            reset = 1'b1;
            for (int j = 0; j < len; j++) begin
                tick();
                compared++;
                if (vgaData !== 14'h3000) begin
                    mismatched++;
                    $display("FAIL rand_reset it%0d: got %h want 3000", it, vgaData);
                end
            end
            reset = 1'b0;
            tick();
            k = 0;
            compared++;
            if (vgaData !== 14'h3FFF) begin
                mismatched++;
                $display("FAIL rand_release it%0d: got %h want 3fff", it, vgaData);
            end
        end
    endtask

    initial begin
        spot_t frame0_spots[];
        spot_t frame10_spots[];
        compared   = 0;
        mismatched = 0;
        k          = 0;
        reset      = 1'b1;

        frame0_spots = new[7];
        frame0_spots[0] = '{5, 10, 14'h3FFF};
        frame0_spots[1] = '{40, 10, 14'h3F00};
        frame0_spots[2] = '{10, 35, 14'h3FF0};
        frame0_spots[3] = '{56, 35, 14'h3000};
        frame0_spots[4] = '{63, 35, 14'h3888};
        frame0_spots[5] = '{70, 35, 14'h1000};
        frame0_spots[6] = '{20, 39, 14'h3888};

        frame10_spots = new[9];
        frame10_spots[0] = '{20, 9, 14'h30FF};
        frame10_spots[1] = '{0, 10, 14'h3888};
        frame10_spots[2] = '{9, 10, 14'h3FF0};
        frame10_spots[3] = '{10, 10, 14'h3FFF};
        frame10_spots[4] = '{41, 10, 14'h3FFF};
        frame10_spots[5] = '{42, 10, 14'h3F00};
        frame10_spots[6] = '{10, 39, 14'h3FFF};
        frame10_spots[7] = '{41, 41, 14'h3000};
        frame10_spots[8] = '{20, 42, 14'h2000};

        test_reset();
        test_line();
        test_pixels(0, frame0_spots);
        test_frame(10 * FT - 1);
        test_pixels(10, frame10_spots);
        test_mid_reset();
        test_random_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
